// File: rtl/params_pkg.sv
// Shared AXI widths, arbiter state encoding and response codes for the AXI arbiters.
package params_pkg;

  localparam int unsigned AXI_ID_WIDTH   = 5;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 8;
  localparam int unsigned AXI_LEN_WIDTH  = 8;

  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_AW,
    ARB_WDAT
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  int unsigned cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!found && req[cand[IW-1:0]]) begin
        found               = 1'b1;
        idx                 = cand[IW-1:0];
        gnt[cand[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI4 write-path arbiter: round-robin per burst, registered AW, W locked until WLAST,
// B routed back by the master index carried in the upper BID bits.
module axi_wr_arbiter
  import params_pkg::*;
#(
  parameter int unsigned NUM_MST    = 2,
  parameter int unsigned ID_WIDTH   = AXI_ID_WIDTH,
  parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = AXI_LEN_WIDTH,
  localparam int unsigned IDX_W     = $clog2(NUM_MST),
  localparam int unsigned M_ID_W    = ID_WIDTH + IDX_W,
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [NUM_MST-1:0]              s_awvalid,
  output logic [NUM_MST-1:0]              s_awready,
  input  logic [NUM_MST*ID_WIDTH-1:0]     s_awid,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [NUM_MST*LEN_WIDTH-1:0]    s_awlen,
  input  logic [NUM_MST-1:0]              s_wvalid,
  output logic [NUM_MST-1:0]              s_wready,
  input  logic [NUM_MST-1:0]              s_wlast,
  input  logic [NUM_MST*DATA_WIDTH-1:0]   s_wdata,
  input  logic [NUM_MST*STRB_W-1:0]       s_wstrb,
  output logic [NUM_MST-1:0]              s_bvalid,
  input  logic [NUM_MST-1:0]              s_bready,
  output logic [ID_WIDTH-1:0]             s_bid,
  output logic [1:0]                      s_bresp,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [M_ID_W-1:0]               m_awid,
  output logic [ADDR_WIDTH-1:0]           m_awaddr,
  output logic [LEN_WIDTH-1:0]            m_awlen,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  output logic                            m_wlast,
  output logic [DATA_WIDTH-1:0]           m_wdata,
  output logic [STRB_W-1:0]               m_wstrb,
  input  logic                            m_bvalid,
  output logic                            m_bready,
  input  logic [M_ID_W-1:0]               m_bid,
  input  logic [1:0]                      m_bresp,
  output logic                            arb_err
);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [NUM_MST-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_found;
  logic                  awvalid_q, awvalid_d;
  logic [M_ID_W-1:0]     awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [LEN_WIDTH-1:0]  awlen_q, awlen_d;
  logic                  arb_err_q;
  logic [IDX_W-1:0]      b_idx;
  logic                  b_idx_ok;
  logic                  w_done;

  rr_arbiter #(
    .N  (NUM_MST),
    .IW (IDX_W)
  ) u_rr (
    .req   (s_awvalid),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    awvalid_d = awvalid_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_found) begin
          state_d   = ARB_AW;
          grant_d   = arb_idx;
          rr_ptr_d  = (arb_idx == IDX_W'(NUM_MST - 1)) ? '0 : arb_idx + 1'b1;
          awvalid_d = 1'b1;
          awid_d    = {arb_idx, s_awid[arb_idx*ID_WIDTH +: ID_WIDTH]};
          awaddr_d  = s_awaddr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          awlen_d   = s_awlen[arb_idx*LEN_WIDTH +: LEN_WIDTH];
        end
      end
      ARB_AW: begin
        if (m_awready) begin
          state_d   = ARB_WDAT;
          awvalid_d = 1'b0;
        end
      end
      ARB_WDAT: begin
        if (w_done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Gated by reset so a master holding AWVALID through reset never sees a handshake.
  assign s_awready = (ARESETn && state_q == ARB_IDLE) ? arb_gnt : '0;

  assign m_awvalid = awvalid_q;
  assign m_awid    = awid_q;
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;

  always_comb begin
    m_wvalid = 1'b0;
    m_wlast  = 1'b0;
    m_wdata  = '0;
    m_wstrb  = '0;
    s_wready = '0;
    if (state_q == ARB_WDAT) begin
      m_wvalid          = s_wvalid[grant_q];
      m_wlast           = s_wlast[grant_q];
      m_wdata           = s_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
      m_wstrb           = s_wstrb[grant_q*STRB_W +: STRB_W];
      s_wready[grant_q] = m_wready;
    end
  end

  assign w_done = m_wvalid & m_wready & m_wlast;

  // Responses for a master index that does not exist are accepted and dropped.
  assign b_idx    = m_bid[M_ID_W-1 -: IDX_W];
  assign b_idx_ok = ({1'b0, b_idx} < (IDX_W + 1)'(NUM_MST));

  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b1;
    if (b_idx_ok) begin
      s_bvalid[b_idx] = m_bvalid;
      m_bready        = s_bready[b_idx];
    end
  end

  assign s_bid   = m_bid[ID_WIDTH-1:0];
  assign s_bresp = m_bresp;
  assign arb_err = arb_err_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      awvalid_q <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      awvalid_q <= awvalid_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      arb_err_q <= arb_err_q | (m_bvalid & ~b_idx_ok);
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: transaction-level model checked every cycle plus directed scenarios.
module tb_axi_wr_arbiter;
  import params_pkg::*;

  localparam int NM   = 2;
  localparam int IW   = 1;
  localparam int ID_W = 5;
  localparam int MIDW = ID_W + IW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Two-master instance
  logic [NM-1:0]      s_awvalid = '0, s_awready;
  logic [NM*5-1:0]    s_awid = '0;
  logic [NM*32-1:0]   s_awaddr = '0;
  logic [NM*8-1:0]    s_awlen = '0;
  logic [NM-1:0]      s_wvalid = '0, s_wready, s_wlast = '0;
  logic [NM*8-1:0]    s_wdata = '0;
  logic [NM-1:0]      s_wstrb = '0;
  logic [NM-1:0]      s_bvalid, s_bready = '0;
  logic [4:0]         s_bid;
  logic [1:0]         s_bresp;
  logic               m_awvalid, m_awready = 1'b1;
  logic [MIDW-1:0]    m_awid;
  logic [31:0]        m_awaddr;
  logic [7:0]         m_awlen;
  logic               m_wvalid, m_wready = 1'b1, m_wlast;
  logic [7:0]         m_wdata;
  logic               m_wstrb;
  logic               m_bvalid = 1'b0, m_bready;
  logic [MIDW-1:0]    m_bid = '0;
  logic [1:0]         m_bresp = '0;
  logic               arb_err;

  // Three-master instance for the out-of-range BID case
  logic [2:0]  s_awvalid3 = '0, s_awready3, s_wvalid3 = '0, s_wready3, s_wlast3 = '0;
  logic [14:0] s_awid3 = '0;
  logic [95:0] s_awaddr3 = '0;
  logic [23:0] s_awlen3 = '0, s_wdata3 = '0;
  logic [2:0]  s_wstrb3 = '0, s_bvalid3, s_bready3 = '0;
  logic [4:0]  s_bid3;
  logic [1:0]  s_bresp3, m_bresp3 = '0;
  logic        m_awvalid3, m_wvalid3, m_wlast3, m_wstrb3, m_bready3, arb_err3;
  logic        m_bvalid3 = 1'b0;
  logic [6:0]  m_awid3, m_bid3 = '0;
  logic [31:0] m_awaddr3;
  logic [7:0]  m_awlen3, m_wdata3;

  axi_wr_arbiter #(.NUM_MST(NM)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_bid(s_bid), .s_bresp(s_bresp), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .arb_err(arb_err)
  );

  axi_wr_arbiter #(.NUM_MST(3)) dut3 (
    .ACLK(clk), .ARESETn(rst_n),
    .s_awvalid(s_awvalid3), .s_awready(s_awready3), .s_awid(s_awid3), .s_awaddr(s_awaddr3),
    .s_awlen(s_awlen3), .s_wvalid(s_wvalid3), .s_wready(s_wready3), .s_wlast(s_wlast3),
    .s_wdata(s_wdata3), .s_wstrb(s_wstrb3), .s_bvalid(s_bvalid3), .s_bready(s_bready3),
    .s_bid(s_bid3), .s_bresp(s_bresp3), .m_awvalid(m_awvalid3), .m_awready(1'b1),
    .m_awid(m_awid3), .m_awaddr(m_awaddr3), .m_awlen(m_awlen3), .m_wvalid(m_wvalid3),
    .m_wready(1'b1), .m_wlast(m_wlast3), .m_wdata(m_wdata3), .m_wstrb(m_wstrb3),
    .m_bvalid(m_bvalid3), .m_bready(m_bready3), .m_bid(m_bid3), .m_bresp(m_bresp3),
    .arb_err(arb_err3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner among req after the last granted master, wrapping.
  function automatic int pick(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++) begin
      if (req[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  // Transaction-level model
  bit              mdl_busy = 0, mdl_aw_pend = 0, mdl_err = 0;
  int              mdl_g = 0, mdl_last = NM - 1, pk, bi;
  logic [MIDW-1:0] exp_awid;
  logic [31:0]     exp_awaddr;
  logic [7:0]      exp_awlen;
  logic [NM-1:0]   exp_awready, exp_wready, exp_bvalid;
  logic            exp_wvalid, exp_bready, in_w;

  int              grant_log[$];
  logic [7:0]      wlog[$];
  logic [45:0]     aw_log[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mdl_busy = 0; mdl_aw_pend = 0; mdl_err = 0; mdl_last = NM - 1;
    end
    pk = pick(s_awvalid, mdl_last);
    exp_awready = '0;
    if (rst_n && !mdl_busy && pk >= 0) exp_awready[pk] = 1'b1;
    chk("s_awready", s_awready, exp_awready);
    chk("m_awvalid", m_awvalid, mdl_aw_pend);
    if (mdl_aw_pend) begin
      chk("m_awid", m_awid, exp_awid);
      chk("m_awaddr", m_awaddr, exp_awaddr);
      chk("m_awlen", m_awlen, exp_awlen);
    end
    in_w       = mdl_busy && !mdl_aw_pend;
    exp_wvalid = in_w && s_wvalid[mdl_g];
    exp_wready = '0;
    if (in_w) exp_wready[mdl_g] = m_wready;
    chk("m_wvalid", m_wvalid, exp_wvalid);
    chk("s_wready", s_wready, exp_wready);
    if (exp_wvalid) begin
      chk("m_wdata", m_wdata, s_wdata[mdl_g*8 +: 8]);
      chk("m_wstrb", m_wstrb, s_wstrb[mdl_g]);
      chk("m_wlast", m_wlast, s_wlast[mdl_g]);
    end
    bi = int'(m_bid >> ID_W);
    exp_bvalid = '0;
    exp_bready = 1'b1;
    if (bi < NM) begin
      exp_bvalid[bi] = m_bvalid;
      exp_bready     = s_bready[bi];
    end
    chk("s_bvalid", s_bvalid, exp_bvalid);
    chk("m_bready", m_bready, exp_bready);
    if (m_bvalid) begin
      chk("s_bid", s_bid, m_bid[4:0]);
      chk("s_bresp", s_bresp, m_bresp);
    end
    chk("arb_err", arb_err, mdl_err);
    // Logs of what the DUT actually did, for the directed checks.
    for (int i = 0; i < NM; i++) if (s_awready[i]) grant_log.push_back(i);
    if (m_wvalid && m_wready) wlog.push_back(m_wdata);
    if (m_awvalid && m_awready) aw_log.push_back({m_awid, m_awaddr, m_awlen});
    // Advance the model across the coming edge.
    if (rst_n) begin
      if (exp_awready != '0) begin
        mdl_g = pk; mdl_last = pk; mdl_busy = 1; mdl_aw_pend = 1;
        exp_awid   = MIDW'((pk << ID_W) | int'(s_awid[pk*ID_W +: ID_W]));
        exp_awaddr = s_awaddr[pk*32 +: 32];
        exp_awlen  = s_awlen[pk*8 +: 8];
      end else if (mdl_aw_pend && m_awready) begin
        mdl_aw_pend = 0;
      end else if (exp_wvalid && m_wready && s_wlast[mdl_g]) begin
        mdl_busy = 0;
      end
      if (m_bvalid && bi >= NM) mdl_err = 1;
    end
  end

  bit wtoggle = 0;
  initial forever begin
    @(posedge clk); #1;
    if (wtoggle) m_wready = ~m_wready;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last W beat.
  task automatic master_burst(input int m, input logic [4:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [7:0] base);
    int t;
    s_awvalid[m] = 1'b1;
    s_awid[m*5 +: 5] = id;
    s_awaddr[m*32 +: 32] = addr;
    s_awlen[m*8 +: 8] = len;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_awready[m] && t < 300);
    if (!s_awready[m]) begin
      chk($sformatf("aw_timeout_m%0d", m), 0, 1);
      s_awvalid[m] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_awvalid[m] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_wvalid[m] = 1'b1;
      s_wdata[m*8 +: 8] = base + 8'(b);
      s_wstrb[m] = 1'b1;
      s_wlast[m] = (b == int'(len));
      t = 0;
      do begin @(negedge clk); t++; end while (!s_wready[m] && t < 300);
      if (!s_wready[m]) begin
        chk($sformatf("w_timeout_m%0d", m), 0, 1);
        s_wvalid[m] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_wvalid[m] = 1'b0;
    s_wlast[m]  = 1'b0;
  endtask

  logic [7:0] exp_t3 [12] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21,
                              8'h30, 8'h31, 8'h40, 8'h41, 8'h50, 8'h51};
  int g0, w0, a0, t;

  initial begin
    // T1: reset held with both masters requesting
    @(posedge clk); #1;
    s_awvalid = 2'b11;
    repeat (2) @(negedge clk);
    chk("t1_s_awready", s_awready, 0);
    chk("t1_m_awvalid", m_awvalid, 0);
    chk("t1_m_aw_payload", {m_awid, m_awaddr, m_awlen}, 0);
    chk("t1_w_outputs", {m_wvalid, s_wready, m_wlast, m_wdata, m_wstrb}, 0);
    chk("t1_b_outputs", {s_bvalid, m_bready}, 0);
    chk("t1_arb_err", arb_err, 0);
    g0 = grant_log.size();
    w0 = wlog.size();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T3: contention, three bursts each
    fork
      begin
        for (int r = 0; r < 3; r++) master_burst(0, 5'h01, 32'h100, 8'd1, 8'(r * 32));
      end
      begin
        for (int r = 0; r < 3; r++) master_burst(1, 5'h02, 32'h200, 8'd1, 8'(r * 32 + 16));
      end
    join
    chk("t1_first_grant_m0", grant_log[g0], 0);
    chk("t3_grant_count", grant_log.size() - g0, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), grant_log[g0 + i], i % 2);
    chk("t3_beat_count", wlog.size() - w0, 12);
    for (int i = 0; i < 12; i++) chk($sformatf("t3_beat%0d", i), wlog[w0 + i], exp_t3[i]);

    // T2: single burst from m1
    do_reset();
    w0 = wlog.size();
    a0 = aw_log.size();
    fork master_burst(1, 5'h03, 32'h1000, 8'd3, 8'h10); join_none
    @(negedge clk);
    chk("t2_awready_pulse", s_awready, 2'b10);
    @(negedge clk);
    chk("t2_awvalid_1cycle", m_awvalid, 1);
    chk("t2_awid", m_awid, 6'h23);
    wait fork;
    chk("t2_aw_count", aw_log.size() - a0, 1);
    chk("t2_aw_log", aw_log[a0], {6'h23, 32'h1000, 8'd3});
    chk("t2_beat_count", wlog.size() - w0, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_beat%0d", i), wlog[w0 + i], 8'h10 + 8'(i));
    @(negedge clk);
    chk("t2_idle_after", {m_awvalid, m_wvalid, s_wready}, 0);

    // T4: AW and W backpressure
    do_reset();
    w0 = wlog.size();
    m_awready = 1'b0;
    fork master_burst(1, 5'h0A, 32'h2000, 8'd3, 8'h40); join_none
    t = 0;
    do begin @(negedge clk); t++; end while (!m_awvalid && t < 20);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("t4_aw_stable%0d", c), {m_awvalid, m_awid, m_awaddr, m_awlen},
          {1'b1, 6'h2A, 32'h2000, 8'd3});
    end
    @(posedge clk); #1;
    m_awready = 1'b1;
    wtoggle = 1;
    wait fork;
    wtoggle = 0;
    m_wready = 1'b1;
    chk("t4_beat_count", wlog.size() - w0, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_beat%0d", i), wlog[w0 + i], 8'h40 + 8'(i));

    // T5: B routing with backpressure from m1
    @(posedge clk); #1;
    m_bvalid = 1'b1; m_bid = 6'h07; m_bresp = 2'b00; s_bready = 2'b11;
    @(negedge clk);
    chk("t5_m0_bvalid", s_bvalid, 2'b01);
    chk("t5_m0_bid", s_bid, 5'h07);
    chk("t5_m0_bready", m_bready, 1);
    @(posedge clk); #1;
    m_bid = 6'h22; m_bresp = AXI_RESP_SLVERR; s_bready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t5_bready_low%0d", c), {m_bready, s_bvalid}, 3'b010);
    end
    @(posedge clk); #1;
    s_bready = 2'b11;
    @(negedge clk);
    chk("t5_m1_accept", {m_bready, s_bvalid, s_bid, s_bresp}, {1'b1, 2'b10, 5'h02, 2'b10});
    @(posedge clk); #1;
    m_bvalid = 1'b0;

    // T6: three masters, BID index 3 does not exist
    chk("t6_idle_outputs", {s_awready3, m_awvalid3, m_wvalid3, s_wready3}, 0);
    chk("t6_payload_zero", {m_awid3, m_awaddr3, m_awlen3, m_wdata3, m_wstrb3, m_wlast3}, 0);
    chk("t6_err_before", arb_err3, 0);
    m_bvalid3 = 1'b1; m_bid3 = 7'h49; s_bready3 = 3'b111;
    @(negedge clk);
    chk("t6_valid_idx2", {s_bvalid3, m_bready3, s_bid3, s_bresp3}, {3'b100, 1'b1, 5'h09, 2'b00});
    @(posedge clk); #1;
    chk("t6_err_not_yet", arb_err3, 0);
    m_bid3 = 7'h64; s_bready3 = 3'b000;
    @(negedge clk);
    chk("t6_sink", {m_bready3, s_bvalid3}, 4'b1000);
    @(posedge clk); #1;
    m_bvalid3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t6_err_sticky%0d", c), arb_err3, 1);
    end
    do_reset();
    @(negedge clk);
    chk("t6_err_cleared", arb_err3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
